// File: rtl/inst_fetch.sv
// Instruction fetch stage: assembles 32-bit little-endian instructions from a byte-wide
// memory port, holds one completed instruction in a skid buffer, and drives the IF/ID register.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        stall_i,
  input  logic        id_jump_enable_i,
  input  logic [31:0] id_jump_pc_i,
  input  logic        ex_jump_enable_i,
  input  logic [31:0] ex_jump_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] next_pc_o
);

  // Memory handshake: a byte transfers in any cycle where mem_req_o and mem_ack_i are both
  // high; mem_data_i is valid in that same cycle and mem_addr_o is held until then.

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] asm_q, asm_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_npc_q, buf_npc_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] npc_q, npc_d;

  logic        fetching;
  logic        ack;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        complete;
  logic [31:0] comp_inst;
  logic [31:0] pc_plus4;

  always_comb begin
    fetching    = (state_q == S_FETCH);
    mem_req_o   = fetching & rdy & rst_n;
    mem_addr_o  = fetching ? (pc_q + {30'd0, cnt_q}) : pc_q;
    ack         = mem_req_o & mem_ack_i;
    // A stalled decode cannot be acting on its own jump, so only execute redirects then.
    redirect    = ex_jump_enable_i | (id_jump_enable_i & ~stall_i);
    redirect_pc = ex_jump_enable_i ? ex_jump_pc_i : id_jump_pc_i;
    complete    = ack & (cnt_q == 2'd3) & ~redirect;
    comp_inst   = {mem_data_i, asm_q};
    pc_plus4    = pc_q + 32'd4;
  end

  always_comb begin
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    buf_valid_d = buf_valid_q;
    buf_inst_d  = buf_inst_q;
    buf_npc_d   = buf_npc_q;
    valid_d     = valid_q;
    inst_d      = inst_q;
    npc_d       = npc_q;

    if (redirect) begin
      pc_d        = redirect_pc;
      cnt_d       = 2'd0;
      buf_valid_d = 1'b0;
      valid_d     = 1'b0;
      inst_d      = NOP_INST;
    end else begin
      if (ack) begin
        case (cnt_q)
          2'd0:    asm_d[7:0]   = mem_data_i;
          2'd1:    asm_d[15:8]  = mem_data_i;
          2'd2:    asm_d[23:16] = mem_data_i;
          default: ;
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          pc_d = pc_plus4;
        end
      end

      if (!stall_i) begin
        if (buf_valid_q) begin
          valid_d     = 1'b1;
          inst_d      = buf_inst_q;
          npc_d       = buf_npc_q;
          buf_valid_d = 1'b0;
        end else if (complete) begin
          valid_d = 1'b1;
          inst_d  = comp_inst;
          npc_d   = pc_plus4;
        end else begin
          valid_d = 1'b0;
          inst_d  = NOP_INST;
        end
      end else if (complete) begin
        // Fetch only runs with an empty buffer, so this never overwrites a held entry.
        buf_valid_d = 1'b1;
        buf_inst_d  = comp_inst;
        buf_npc_d   = pc_plus4;
      end
    end

    state_d = buf_valid_d ? S_HOLD : S_FETCH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      cnt_q       <= 2'd0;
      asm_q       <= 24'd0;
      buf_valid_q <= 1'b0;
      buf_inst_q  <= NOP_INST;
      buf_npc_q   <= 32'd0;
      valid_q     <= 1'b0;
      inst_q      <= NOP_INST;
      npc_q       <= 32'd0;
    end else if (rdy) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      buf_valid_q <= buf_valid_d;
      buf_inst_q  <= buf_inst_d;
      buf_npc_q   <= buf_npc_d;
      valid_q     <= valid_d;
      inst_q      <= inst_d;
      npc_q       <= npc_d;
    end
  end

  assign valid_o   = valid_q;
  assign inst_o    = inst_q;
  assign next_pc_o = npc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: byte memory model acks every request, outputs are checked
// against hand-computed values one time unit after each rising edge.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        stall_i;
  logic        id_jump_enable_i;
  logic [31:0] id_jump_pc_i;
  logic        ex_jump_enable_i;
  logic [31:0] ex_jump_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [7:0]  mem_data_i;
  logic        valid_o;
  logic [31:0] inst_o;
  logic [31:0] next_pc_o;

  logic        ack_en;
  logic [7:0]  mem [256];
  logic [31:0] exp_q [$];
  logic [31:0] exp_inst;
  int          n_total;
  int          n_bad;

  inst_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rdy              (rdy),
    .stall_i          (stall_i),
    .id_jump_enable_i (id_jump_enable_i),
    .id_jump_pc_i     (id_jump_pc_i),
    .ex_jump_enable_i (ex_jump_enable_i),
    .ex_jump_pc_i     (ex_jump_pc_i),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_ack_i        (mem_ack_i),
    .mem_data_i       (mem_data_i),
    .valid_o          (valid_o),
    .inst_o           (inst_o),
    .next_pc_o        (next_pc_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory model: same-cycle ack of every request while enabled
  assign mem_data_i = mem[mem_addr_o[7:0]];
  assign mem_ack_i  = ack_en & mem_req_o;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    rdy              = 1'b1;
    stall_i          = 1'b0;
    id_jump_enable_i = 1'b0;
    id_jump_pc_i     = 32'd0;
    ex_jump_enable_i = 1'b0;
    ex_jump_pc_i     = 32'd0;
    ack_en           = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic ex_jump(input logic [31:0] target);
    ex_jump_enable_i = 1'b1;
    ex_jump_pc_i     = target;
    tick();
    ex_jump_enable_i = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    // 0x00: 00100093, 0x04: 00200113, 0x08: 00300193
    mem[0] = 8'h93; mem[1] = 8'h00; mem[2]  = 8'h10; mem[3]  = 8'h00;
    mem[4] = 8'h13; mem[5] = 8'h01; mem[6]  = 8'h20; mem[7]  = 8'h00;
    mem[8] = 8'h93; mem[9] = 8'h01; mem[10] = 8'h30; mem[11] = 8'h00;
    // 0x80: 00a00513
    mem[8'h80] = 8'h13; mem[8'h81] = 8'h05; mem[8'h82] = 8'ha0; mem[8'h83] = 8'h00;
    // 0x40: garbage that must never be seen
    mem[8'h40] = 8'hde; mem[8'h41] = 8'had; mem[8'h42] = 8'hbe; mem[8'h43] = 8'hef;
    // 0xFFFFFFFC: 00000537
    mem[8'hfc] = 8'h37; mem[8'hfd] = 8'h05; mem[8'hfe] = 8'h00; mem[8'hff] = 8'h00;

    // Reset
    rst_n = 1'b0; rdy = 1'b1; stall_i = 1'b0; ack_en = 1'b0;
    id_jump_enable_i = 1'b0; id_jump_pc_i = 32'd0;
    ex_jump_enable_i = 1'b0; ex_jump_pc_i = 32'd0;
    tick();
    chk("rst_req_low", {31'd0, mem_req_o}, 32'd0);
    do_reset();
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_inst", inst_o, 32'h0000_0013);
    chk("rst_npc", next_pc_o, 32'd0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd1);
    chk("rst_addr", mem_addr_o, 32'd0);

    // Streaming fetch
    exp_q.push_back(32'h0010_0093);
    exp_q.push_back(32'h0020_0113);
    ack_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("stream_addr", mem_addr_o, 32'(i));
      if (i == 3) chk("stream_nvalid3", {31'd0, valid_o}, 32'd0);
      if (i == 4 || i == 8) begin
        chk("stream_valid", {31'd0, valid_o}, 32'd1);
        exp_inst = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        chk("stream_inst", inst_o, exp_inst);
        chk("stream_npc", next_pc_o, (i == 4) ? 32'd4 : 32'd8);
      end
      if (i == 5) begin
        chk("stream_bubble", {31'd0, valid_o}, 32'd0);
        chk("stream_bubble_inst", inst_o, 32'h0000_0013);
        chk("stream_bubble_npc", next_pc_o, 32'd4);
      end
    end
    chk("stream_q_empty", 32'(exp_q.size()), 32'd0);

    // Stall with buffer
    do_reset();
    ack_en = 1'b1;
    repeat (4) tick();
    chk("stall_first", inst_o, 32'h0010_0093);
    stall_i = 1'b1;
    repeat (4) tick();
    chk("stall_hold_valid", {31'd0, valid_o}, 32'd1);
    chk("stall_hold_inst", inst_o, 32'h0010_0093);
    chk("stall_hold_npc", next_pc_o, 32'd4);
    chk("stall_req_off", {31'd0, mem_req_o}, 32'd0);
    chk("stall_addr", mem_addr_o, 32'd8);
    tick();
    chk("stall_still_off", {31'd0, mem_req_o}, 32'd0);
    chk("stall_still_inst", inst_o, 32'h0010_0093);
    stall_i = 1'b0;
    tick();
    chk("unstall_inst", inst_o, 32'h0020_0113);
    chk("unstall_npc", next_pc_o, 32'd8);
    chk("unstall_req", {31'd0, mem_req_o}, 32'd1);
    chk("unstall_addr", mem_addr_o, 32'd8);
    repeat (4) tick();
    chk("unstall_next_inst", inst_o, 32'h0030_0193);
    chk("unstall_next_npc", next_pc_o, 32'd12);

    // Redirect priority on the third ack
    do_reset();
    ack_en = 1'b1;
    repeat (2) tick();
    chk("redir_pre_addr", mem_addr_o, 32'd2);
    id_jump_enable_i = 1'b1; id_jump_pc_i = 32'h40;
    ex_jump_enable_i = 1'b1; ex_jump_pc_i = 32'h80;
    tick();
    id_jump_enable_i = 1'b0; ex_jump_enable_i = 1'b0;
    chk("redir_addr", mem_addr_o, 32'h80);
    chk("redir_valid", {31'd0, valid_o}, 32'd0);
    chk("redir_inst", inst_o, 32'h0000_0013);
    repeat (3) tick();
    chk("redir_nvalid", {31'd0, valid_o}, 32'd0);
    tick();
    chk("redir_tgt_inst", inst_o, 32'h00a0_0513);
    chk("redir_tgt_npc", next_pc_o, 32'h84);

    // ID jump ignored under stall, EX jump flushes under stall
    do_reset();
    ack_en = 1'b1;
    repeat (4) tick();
    stall_i = 1'b1;
    id_jump_enable_i = 1'b1; id_jump_pc_i = 32'h40;
    tick();
    id_jump_enable_i = 1'b0;
    chk("idst_addr", mem_addr_o, 32'd5);
    chk("idst_inst", inst_o, 32'h0010_0093);
    repeat (3) tick();
    chk("idst_hold_addr", mem_addr_o, 32'd8);
    chk("idst_hold_req", {31'd0, mem_req_o}, 32'd0);
    ex_jump(32'h80);
    chk("exst_valid", {31'd0, valid_o}, 32'd0);
    chk("exst_inst", inst_o, 32'h0000_0013);
    chk("exst_addr", mem_addr_o, 32'h80);
    chk("exst_req", {31'd0, mem_req_o}, 32'd1);
    repeat (4) tick();
    chk("exst_buf_req", {31'd0, mem_req_o}, 32'd0);
    chk("exst_buf_outnop", inst_o, 32'h0000_0013);
    stall_i = 1'b0;
    tick();
    chk("exst_rel_inst", inst_o, 32'h00a0_0513);
    chk("exst_rel_npc", next_pc_o, 32'h84);

    // Wrap and rdy freeze
    do_reset();
    ack_en = 1'b1;
    ex_jump(32'hffff_fffc);
    chk("wrap_addr0", mem_addr_o, 32'hffff_fffc);
    repeat (2) tick();
    chk("wrap_addr2", mem_addr_o, 32'hffff_fffe);
    rdy = 1'b0;
    #1;
    chk("rdy_req_off", {31'd0, mem_req_o}, 32'd0);
    tick();
    tick();
    chk("rdy_addr_frozen", mem_addr_o, 32'hffff_fffe);
    rdy = 1'b1;
    #1;
    chk("rdy_req_back", {31'd0, mem_req_o}, 32'd1);
    tick();
    chk("wrap_addr3", mem_addr_o, 32'hffff_ffff);
    tick();
    chk("wrap_valid", {31'd0, valid_o}, 32'd1);
    chk("wrap_inst", inst_o, 32'h0000_0537);
    chk("wrap_npc", next_pc_o, 32'd0);
    chk("wrap_next_addr", mem_addr_o, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
